// File: rtl/calc_pkg.sv
// Shared types and key codes for the calculator entry controller.
package calc_pkg;

    typedef logic [3:0][3:0] bcd4_t;

    typedef enum logic [1:0] {
        ENT_A,
        ENT_B,
        CALC,
        SHOW
    } estado_t;

    localparam logic [3:0] KEY_NEXT = 4'hA;
    localparam logic [3:0] KEY_EQ   = 4'hB;
    localparam logic [3:0] KEY_CLR  = 4'hC;

endpackage

// File: rtl/reg_bcd_shift.sv
// 4-digit BCD entry register: shifts digits in from the right, saturating at N_DIG digits.
module reg_bcd_shift
    import calc_pkg::*;
#(
    parameter int unsigned N_DIG = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic            load_one,
    input  logic            shift,
    input  logic [3:0]      digit,
    output logic [3:0][3:0] q,
    output logic            full
);

    logic [2:0] cnt;

    assign full = (cnt == 3'(N_DIG));

    // Clear beats load-one beats shift; a shift with all digits present is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q   <= '0;
            cnt <= '0;
        end else if (clr) begin
            q   <= '0;
            cnt <= '0;
        end else if (load_one) begin
            q   <= {12'h000, digit};
            cnt <= 3'd1;
        end else if (shift && !full) begin
            q   <= {q[2:0], digit};
            cnt <= cnt + 3'd1;
        end
    end

endmodule

// File: rtl/ctrl_entrada_calc.sv
// Keypad entry sequencer: collects operands A and B, starts the arithmetic
// core, waits for completion (with timeout) and selects the result display.
module ctrl_entrada_calc
    import calc_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 1024,
    parameter int unsigned N_DIG       = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [3:0]      tecla,
    input  logic            tecla_valida,
    input  logic            listo,
    output logic [3:0][3:0] numero,
    output logic [3:0][3:0] op_a,
    output logic [3:0][3:0] op_b,
    output logic            inicio,
    output logic            ent,
    output logic            error
);

    localparam int unsigned TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    estado_t        state, state_d;
    logic [TW-1:0]  timer, timer_d;
    bcd4_t          op_a_d, op_b_d;
    logic           inicio_d, ent_d, error_d;
    logic           num_clr, num_load, num_shift, num_full;
    logic           is_dig, is_next, is_eq, is_clr;

    assign is_dig  = tecla_valida && (tecla <= 4'd9);
    assign is_next = tecla_valida && (tecla == KEY_NEXT);
    assign is_eq   = tecla_valida && (tecla == KEY_EQ);
    assign is_clr  = tecla_valida && (tecla == KEY_CLR);

    reg_bcd_shift #(.N_DIG(N_DIG)) u_numero (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (num_clr),
        .load_one (num_load),
        .shift    (num_shift),
        .digit    (tecla),
        .q        (numero),
        .full     (num_full)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ENT_A;
        else        state <= state_d;
    end

    // Next-state and next-output decode; CLR overrides everything, listo beats timeout.
    always_comb begin
        state_d   = state;
        timer_d   = timer;
        op_a_d    = op_a;
        op_b_d    = op_b;
        inicio_d  = 1'b0;
        ent_d     = ent;
        error_d   = error;
        num_clr   = 1'b0;
        num_load  = 1'b0;
        num_shift = 1'b0;

        if (is_clr) begin
            state_d = ENT_A;
            timer_d = '0;
            op_a_d  = '0;
            op_b_d  = '0;
            ent_d   = 1'b0;
            error_d = 1'b0;
            num_clr = 1'b1;
        end else begin
            unique case (state)
                ENT_A: begin
                    if (is_dig && !num_full) begin
                        num_shift = 1'b1;
                        error_d   = 1'b0;
                    end else if (is_next) begin
                        op_a_d  = numero;
                        num_clr = 1'b1;
                        error_d = 1'b0;
                        state_d = ENT_B;
                    end
                end
                ENT_B: begin
                    if (is_dig && !num_full) begin
                        num_shift = 1'b1;
                        error_d   = 1'b0;
                    end else if (is_eq) begin
                        op_b_d   = numero;
                        inicio_d = 1'b1;
                        timer_d  = '0;
                        error_d  = 1'b0;
                        state_d  = CALC;
                    end
                end
                CALC: begin
                    if (listo) begin
                        ent_d   = 1'b1;
                        state_d = SHOW;
                    end else if (timer == TW'(TIMEOUT_CYC - 1)) begin
                        error_d = 1'b1;
                        op_a_d  = '0;
                        op_b_d  = '0;
                        num_clr = 1'b1;
                        ent_d   = 1'b0;
                        state_d = ENT_A;
                    end else begin
                        timer_d = timer + 1'b1;
                    end
                end
                SHOW: begin
                    if (is_dig) begin
                        ent_d    = 1'b0;
                        num_load = 1'b1;
                        op_a_d   = '0;
                        op_b_d   = '0;
                        error_d  = 1'b0;
                        state_d  = ENT_A;
                    end
                end
                default: state_d = ENT_A;
            endcase
        end
    end

    // Registered outputs and timeout counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer  <= '0;
            op_a   <= '0;
            op_b   <= '0;
            inicio <= 1'b0;
            ent    <= 1'b0;
            error  <= 1'b0;
        end else begin
            timer  <= timer_d;
            op_a   <= op_a_d;
            op_b   <= op_b_d;
            inicio <= inicio_d;
            ent    <= ent_d;
            error  <= error_d;
        end
    end

endmodule

// File: tb/tb_ctrl_entrada_calc.sv
// Directed self-checking bench for ctrl_entrada_calc (TIMEOUT_CYC = 16).
module tb_ctrl_entrada_calc;

    logic            clk;
    logic            rst_n;
    logic [3:0]      tecla;
    logic            tecla_valida;
    logic            listo;
    logic [3:0][3:0] numero;
    logic [3:0][3:0] op_a;
    logic [3:0][3:0] op_b;
    logic            inicio;
    logic            ent;
    logic            error;

    int unsigned pass_cnt;
    int unsigned total_cnt;

    ctrl_entrada_calc #(.TIMEOUT_CYC(16), .N_DIG(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tecla        (tecla),
        .tecla_valida (tecla_valida),
        .listo        (listo),
        .numero       (numero),
        .op_a         (op_a),
        .op_b         (op_b),
        .inicio       (inicio),
        .ent          (ent),
        .error        (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [3:0]  k;
        logic        l;
        logic [15:0] num;
        logic [15:0] a;
        logic [15:0] b;
        logic        ini;
        logic        ent;
        logic        err;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic v, logic [3:0] k, logic l, logic [15:0] num,
                                logic [15:0] a, logic [15:0] b, logic ini, logic en, logic err);
        vec_t r;
        r.v = v; r.k = k; r.l = l; r.num = num; r.a = a; r.b = b;
        r.ini = ini; r.ent = en; r.err = err;
        return r;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic check_all(input string tag, input logic [15:0] num, input logic [15:0] a,
                             input logic [15:0] b, input logic ini, input logic en, input logic err);
        chk({tag, ".numero"}, numero, num);
        chk({tag, ".op_a"},   op_a,   a);
        chk({tag, ".op_b"},   op_b,   b);
        chk({tag, ".inicio"}, 16'(inicio), 16'(ini));
        chk({tag, ".ent"},    16'(ent),    16'(en));
        chk({tag, ".error"},  16'(error),  16'(err));
    endtask

    // One clock: drive at negedge, sample 1 ns after the rising edge.
    task automatic step(input logic v, input logic [3:0] k, input logic l);
        @(negedge clk);
        tecla_valida = v;
        tecla        = k;
        listo        = l;
        @(posedge clk);
        #1;
    endtask

    initial begin
        pass_cnt     = 0;
        total_cnt    = 0;
        rst_n        = 1'b0;
        tecla        = 4'h0;
        tecla_valida = 1'b0;
        listo        = 1'b0;

        // Operand entry, overflow, CALC/SHOW, CLR and CLR-vs-listo vectors.
        tbl.push_back(mk(1, 4'h2, 0, 16'h0002, 16'h0000, 16'h0000, 0, 0, 0));
        tbl.push_back(mk(1, 4'h6, 0, 16'h0026, 16'h0000, 16'h0000, 0, 0, 0));
        tbl.push_back(mk(1, 4'h0, 0, 16'h0260, 16'h0000, 16'h0000, 0, 0, 0));
        tbl.push_back(mk(1, 4'h5, 0, 16'h2605, 16'h0000, 16'h0000, 0, 0, 0));
        tbl.push_back(mk(1, 4'hB, 0, 16'h2605, 16'h0000, 16'h0000, 0, 0, 0));
        tbl.push_back(mk(1, 4'h7, 0, 16'h2605, 16'h0000, 16'h0000, 0, 0, 0));
        tbl.push_back(mk(0, 4'h3, 0, 16'h2605, 16'h0000, 16'h0000, 0, 0, 0));
        tbl.push_back(mk(1, 4'hA, 0, 16'h0000, 16'h2605, 16'h0000, 0, 0, 0));
        tbl.push_back(mk(1, 4'hA, 0, 16'h0000, 16'h2605, 16'h0000, 0, 0, 0));
        tbl.push_back(mk(1, 4'h1, 0, 16'h0001, 16'h2605, 16'h0000, 0, 0, 0));
        tbl.push_back(mk(1, 4'h0, 0, 16'h0010, 16'h2605, 16'h0000, 0, 0, 0));
        tbl.push_back(mk(1, 4'h4, 0, 16'h0104, 16'h2605, 16'h0000, 0, 0, 0));
        tbl.push_back(mk(1, 4'h6, 0, 16'h1046, 16'h2605, 16'h0000, 0, 0, 0));
        tbl.push_back(mk(1, 4'hB, 0, 16'h1046, 16'h2605, 16'h1046, 1, 0, 0));
        tbl.push_back(mk(0, 4'h0, 0, 16'h1046, 16'h2605, 16'h1046, 0, 0, 0));
        tbl.push_back(mk(1, 4'h5, 0, 16'h1046, 16'h2605, 16'h1046, 0, 0, 0));
        tbl.push_back(mk(1, 4'hA, 0, 16'h1046, 16'h2605, 16'h1046, 0, 0, 0));
        tbl.push_back(mk(1, 4'hB, 0, 16'h1046, 16'h2605, 16'h1046, 0, 0, 0));
        tbl.push_back(mk(1, 4'hF, 0, 16'h1046, 16'h2605, 16'h1046, 0, 0, 0));
        tbl.push_back(mk(0, 4'h0, 0, 16'h1046, 16'h2605, 16'h1046, 0, 0, 0));
        tbl.push_back(mk(0, 4'h0, 1, 16'h1046, 16'h2605, 16'h1046, 0, 1, 0));
        tbl.push_back(mk(0, 4'h0, 0, 16'h1046, 16'h2605, 16'h1046, 0, 1, 0));
        tbl.push_back(mk(1, 4'hA, 0, 16'h1046, 16'h2605, 16'h1046, 0, 1, 0));
        tbl.push_back(mk(1, 4'h9, 0, 16'h0009, 16'h0000, 16'h0000, 0, 0, 0));
        tbl.push_back(mk(1, 4'h1, 0, 16'h0091, 16'h0000, 16'h0000, 0, 0, 0));
        tbl.push_back(mk(1, 4'hC, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0));
        tbl.push_back(mk(1, 4'h1, 0, 16'h0001, 16'h0000, 16'h0000, 0, 0, 0));
        tbl.push_back(mk(1, 4'h2, 0, 16'h0012, 16'h0000, 16'h0000, 0, 0, 0));
        tbl.push_back(mk(1, 4'h3, 0, 16'h0123, 16'h0000, 16'h0000, 0, 0, 0));
        tbl.push_back(mk(1, 4'h4, 0, 16'h1234, 16'h0000, 16'h0000, 0, 0, 0));
        tbl.push_back(mk(1, 4'h5, 0, 16'h1234, 16'h0000, 16'h0000, 0, 0, 0));
        tbl.push_back(mk(1, 4'hD, 0, 16'h1234, 16'h0000, 16'h0000, 0, 0, 0));
        tbl.push_back(mk(1, 4'hC, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0));
        tbl.push_back(mk(1, 4'hA, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0));
        tbl.push_back(mk(1, 4'h8, 0, 16'h0008, 16'h0000, 16'h0000, 0, 0, 0));
        tbl.push_back(mk(1, 4'hB, 0, 16'h0008, 16'h0000, 16'h0008, 1, 0, 0));
        tbl.push_back(mk(0, 4'h0, 0, 16'h0008, 16'h0000, 16'h0008, 0, 0, 0));
        tbl.push_back(mk(1, 4'hC, 1, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0));
        tbl.push_back(mk(0, 4'h0, 1, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0));
        tbl.push_back(mk(1, 4'h4, 0, 16'h0004, 16'h0000, 16'h0000, 0, 0, 0));

        // Reset values.
        #12;
        check_all("reset", 16'h0000, 16'h0000, 16'h0000, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            step(tbl[i].v, tbl[i].k, tbl[i].l);
            check_all($sformatf("vec%0d", i), tbl[i].num, tbl[i].a, tbl[i].b,
                      tbl[i].ini, tbl[i].ent, tbl[i].err);
        end

        // Timeout: no listo for 16 cycles after EQ.
        step(1, 4'hC, 0);
        step(1, 4'h1, 0);
        step(1, 4'hA, 0);
        step(1, 4'h2, 0);
        step(1, 4'hB, 0);
        check_all("to.eq", 16'h0002, 16'h0001, 16'h0002, 1, 0, 0);
        for (int i = 1; i <= 15; i++) begin
            step(0, 4'h0, 0);
            check_all($sformatf("to.wait%0d", i), 16'h0002, 16'h0001, 16'h0002, 0, 0, 0);
        end
        step(0, 4'h0, 0);
        check_all("to.fire", 16'h0000, 16'h0000, 16'h0000, 0, 0, 1);
        step(1, 4'hB, 0);
        check_all("to.ignored_eq", 16'h0000, 16'h0000, 16'h0000, 0, 0, 1);
        step(1, 4'h3, 0);
        check_all("to.key3", 16'h0003, 16'h0000, 16'h0000, 0, 0, 0);

        // listo arriving on the timeout cycle wins.
        step(1, 4'hA, 0);
        step(1, 4'h4, 0);
        step(1, 4'hB, 0);
        check_all("lt.eq", 16'h0004, 16'h0003, 16'h0004, 1, 0, 0);
        for (int i = 1; i <= 15; i++) begin
            step(0, 4'h0, 0);
        end
        step(0, 4'h0, 1);
        check_all("lt.listo", 16'h0004, 16'h0003, 16'h0004, 0, 1, 0);
        step(0, 4'h0, 0);
        check_all("lt.hold", 16'h0004, 16'h0003, 16'h0004, 0, 1, 0);

        // Asynchronous reset mid-entry.
        step(1, 4'hC, 0);
        step(1, 4'h2, 0);
        step(1, 4'h6, 0);
        step(1, 4'h0, 0);
        check_all("re.entry", 16'h0260, 16'h0000, 16'h0000, 0, 0, 0);
        #2;
        rst_n        = 1'b0;
        tecla_valida = 1'b0;
        #1;
        check_all("re.async", 16'h0000, 16'h0000, 16'h0000, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 4'h7, 0);
        check_all("re.key7", 16'h0007, 16'h0000, 16'h0000, 0, 0, 0);

        // Asynchronous reset during CALC while inicio is high.
        step(1, 4'hA, 0);
        step(1, 4'h1, 0);
        step(1, 4'hB, 0);
        check_all("rc.eq", 16'h0001, 16'h0007, 16'h0001, 1, 0, 0);
        #2;
        rst_n        = 1'b0;
        tecla_valida = 1'b0;
        #1;
        check_all("rc.async", 16'h0000, 16'h0000, 16'h0000, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 4'h7, 0);
        check_all("rc.key7", 16'h0007, 16'h0000, 16'h0000, 0, 0, 0);
        step(1, 4'hA, 0);
        check_all("rc.next", 16'h0000, 16'h0007, 16'h0000, 0, 0, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
